// File: rtl/led_probe_pkg.sv
// Shared types and sizing helpers for the LED probe display controller.
package led_probe_pkg;

    typedef enum logic [1:0] {
        PM_DIRECT    = 2'b00,
        PM_SCAN      = 2'b01,
        PM_CHANGE    = 2'b10,
        PM_HEARTBEAT = 2'b11
    } probe_mode_t;

    // Number of LED-wide slices in one probe word.
    function automatic int slice_count(input int dw, input int lw);
        return dw / lw;
    endfunction

    // Index width for n choices, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_probe_ctrl_if.sv
// Probe/LED bundle between the board-facing top and the display controller.
interface led_probe_ctrl_if
    import led_probe_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int LW  = 8
);
    localparam int SW = idx_width(NCH);
    localparam int IW = idx_width(slice_count(DW, LW));

    logic [NCH*DW-1:0] probe;
    logic [SW-1:0]     sel;
    probe_mode_t       mode;
    logic              hold;
    logic [LW-1:0]     led;
    logic [IW-1:0]     byte_idx;

    modport master (output probe, sel, mode, hold, input led, byte_idx);
    modport slave  (input probe, sel, mode, hold, output led, byte_idx);

endinterface

// File: rtl/led_probe_ctrl_dwell_timer.sv
// Free-running dwell counter shared by the scan and heartbeat paths.
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == CW'(DWELL - 1));
    // A clear in the same cycle suppresses the tick so the restart starts clean.
    assign tick   = en && !clr && at_end;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            if (clr || at_end) cnt <= '0;
            else               cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_probe_ctrl.sv
// Debug LED controller: picks one probe word and shows it as direct,
// byte-scan, sticky change-capture or heartbeat.
module led_probe_ctrl
    import led_probe_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int LW    = 8,
    parameter int DWELL = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    led_probe_ctrl_if.slave   bus
);
    localparam int NSL = slice_count(DW, LW);
    localparam int SW  = idx_width(NCH);
    localparam int IW  = idx_width(NSL);

    probe_mode_t   mode_q;
    logic [SW-1:0] sel_q;
    logic [LW-1:0] sticky_q, prev_q, led_q;
    logic [IW-1:0] idx_q;
    logic          hb_q;

    logic [LW-1:0] sticky_d, led_d, low;
    logic [IW-1:0] idx_d;
    logic          hb_d;
    logic [DW-1:0] word;
    logic          reconf, tick;

    assign reconf = (bus.mode != mode_q) || (bus.sel != sel_q);

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        word = bus.probe[0 +: DW];
        for (int k = 1; k < NCH; k++)
            if (bus.sel == SW'(k)) word = bus.probe[k*DW +: DW];
    end

    assign low = word[LW-1:0];

    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (!bus.hold),
        .clr   (reconf),
        .tick  (tick)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sticky_d = reconf ? '0 : (sticky_q | (low ^ prev_q));
        hb_d     = hb_q;
        idx_d    = '0;
        led_d    = low;
        unique case (bus.mode)
            PM_DIRECT: led_d = low;
            PM_SCAN: begin
                if (!reconf) begin
                    if (tick) idx_d = (idx_q == IW'(NSL - 1)) ? '0 : idx_q + 1'b1;
                    else      idx_d = idx_q;
                end
                led_d = word[int'(idx_d)*LW +: LW];
            end
            PM_CHANGE: led_d = sticky_d;
            PM_HEARTBEAT: begin
                if (tick) hb_d = ~hb_q;
                led_d = {hb_d, low[LW-2:0]};
            end
            default: led_d = low;
        endcase
    end

    // Hold freezes everything, including the shadow, so a reconfigure waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= PM_DIRECT;
            sel_q    <= '0;
            sticky_q <= '0;
            prev_q   <= '0;
            led_q    <= '0;
            idx_q    <= '0;
            hb_q     <= 1'b0;
        end else if (!bus.hold) begin
            mode_q   <= bus.mode;
            sel_q    <= bus.sel;
            sticky_q <= sticky_d;
            prev_q   <= low;
            led_q    <= led_d;
            idx_q    <= idx_d;
            hb_q     <= hb_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.byte_idx = idx_q;

endmodule

// File: tb/tb_led_probe_ctrl.sv
// Self-checking bench for led_probe_ctrl: expected LED/index pairs are queued
// as stimulus is applied and compared one edge later.
module tb_led_probe_ctrl;
    import led_probe_pkg::*;

    localparam int NCH   = 3;
    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int DWELL = 4;

    typedef struct {
        string      tag;
        logic [7:0] led;
        logic [1:0] idx;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    led_probe_ctrl_if #(.NCH(NCH), .DW(DW), .LW(LW)) bus ();

    led_probe_ctrl #(.NCH(NCH), .DW(DW), .LW(LW), .DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        bus.probe[k*DW +: DW] = v;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[i*8 +: 8];
    endfunction

    // Queue the expectation for the coming edge, then pop and compare after it.
    task automatic cyc(input logic [7:0] e_led, input logic [1:0] e_idx, input string tag);
        exp_t e;
        sb.push_back('{tag, e_led, e_idx});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_led"}, 32'(bus.led), 32'(e.led));
            check({e.tag, "_idx"}, 32'(bus.byte_idx), 32'(e.idx));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.hold  = 1'b0;
        bus.mode  = PM_DIRECT;
        bus.sel   = 2'd1;
        bus.probe = '0;
        set_ch(1, 32'hDEADBEEF);

        cyc(8'h00, 2'd0, "rst_a");
        cyc(8'h00, 2'd0, "rst_b");
        reset = 1'b0;
        cyc(8'hEF, 2'd0, "rst_release");
        set_ch(1, 32'h12345678);
        cyc(8'h78, 2'd0, "direct_latency");

        set_ch(0, 32'h44332211);
        bus.sel  = 2'd0;
        bus.mode = PM_SCAN;
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < DWELL; c++)
                cyc(byte_of(32'h44332211, s % 4), 2'(s % 4), "scan_wrap");

        bus.hold = 1'b1;
        repeat (10) cyc(8'h11, 2'd0, "hold_frozen");
        bus.hold = 1'b0;
        cyc(8'h22, 2'd1, "hold_release_tick");
        repeat (3) cyc(8'h22, 2'd1, "scan_pre_collide");
        bus.sel = 2'd1;
        cyc(8'h78, 2'd0, "collide_reconf_wins");
        repeat (3) cyc(8'h78, 2'd0, "counter_restart");
        cyc(8'h56, 2'd1, "restart_tick");

        bus.hold = 1'b1;
        bus.mode = PM_DIRECT;
        repeat (2) cyc(8'h56, 2'd1, "hold_defers_reconf");
        bus.hold = 1'b0;
        cyc(8'h78, 2'd0, "deferred_reconf");

        set_ch(2, 32'hCAFE0000);
        bus.sel  = 2'd2;
        bus.mode = PM_CHANGE;
        cyc(8'h00, 2'd0, "chg_enter");
        set_ch(2, 32'hCAFE0005);
        cyc(8'h05, 2'd0, "chg_rise");
        set_ch(2, 32'hCAFE0000);
        cyc(8'h05, 2'd0, "chg_fall_sticky");
        set_ch(2, 32'hCAFE0080);
        cyc(8'h85, 2'd0, "chg_accumulate");
        cyc(8'h85, 2'd0, "chg_keep");
        bus.sel = 2'd3;
        cyc(8'h00, 2'd0, "chg_sel3_clear");
        bus.sel = 2'd2;
        cyc(8'h00, 2'd0, "chg_back_clear");
        cyc(8'h00, 2'd0, "chg_stable");

        set_ch(0, 32'h0000007F);
        bus.sel  = 2'd0;
        bus.mode = PM_HEARTBEAT;
        for (int h = 0; h < 4; h++)
            for (int c = 0; c < DWELL; c++)
                cyc((h % 2 == 1) ? 8'hFF : 8'h7F, 2'd0, "heartbeat");

        bus.mode = PM_DIRECT;
        set_ch(0, 32'h000000A5);
        bus.sel = 2'd3;
        cyc(8'hA5, 2'd0, "oor_sel_ch0");
        set_ch(0, 32'h0000003C);
        cyc(8'h3C, 2'd0, "oor_sel_live");

        set_ch(0, 32'h44332211);
        bus.sel  = 2'd0;
        bus.mode = PM_SCAN;
        repeat (4) cyc(8'h11, 2'd0, "scan2_idx0");
        repeat (4) cyc(8'h22, 2'd1, "scan2_idx1");
        cyc(8'h33, 2'd2, "scan2_idx2");
        reset = 1'b1;
        cyc(8'h00, 2'd0, "rst_mid_scan");
        reset = 1'b0;
        cyc(8'h11, 2'd0, "rst_mid_release");
        set_ch(0, 32'h44332299);
        cyc(8'h99, 2'd0, "scan_live_track");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
